seq_recognizer_ctrl: RTL and testbench
======================================

// Module: seq_recognizer_ctrl
// PURPOSE
//  Run controller for the 3-symbol sequence recognizer datapath (default 11,01,10).
//  - Holds a programmable 3-symbol pattern and accepts a symbol stream over a valid/ready handshake.
//  - Tracks recognition progress, pulses on each match and counts matches.
//  - Stops automatically after a programmed number of matches.
//  - Sits between the symbol source and the status/sequencing logic that arms and reads the recognizer.
// PARAMETERS
//  SYM_W        2     width of one input symbol (x1_x0 pair)
//  CNT_W        8     width of match counter and limit
//  TIMEOUT_CYC  16    idle-cycle limit in RUN (used only with SEQ_CTRL_TIMEOUT_EN)
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  cfg_we       in   1          load cfg_pattern/cfg_limit (honoured only in IDLE or DONE)
//  cfg_pattern  in   3*SYM_W    {p0,p1,p2}: p0 in MSBs, p0 is the first symbol expected
//  cfg_limit    in   CNT_W      matches before DONE; 0 = unlimited
//  start        in   1          arm: enter RUN, clear count and progress
//  stop         in   1          abort RUN -> IDLE
//  x_valid      in   1          symbol present
//  x            in   SYM_W      symbol
//  x_ready      out  1          symbol accepted when x_valid & x_ready
//  busy         out  1          state == RUN
//  done         out  1          state == DONE
//  z            out  1          1-cycle match pulse (registered)
//  match_count  out  CNT_W      matches since last start
//  timeout      out  1          sticky timeout flag (0 when macro absent)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, progress=S0, pattern={11,01,10}, limit=0, match_count=0.
//   - z=0, timeout=0, busy=0, done=0, x_ready=0.
//  Top FSM: IDLE, RUN, DONE.
//   - IDLE -start-> RUN.
//   - RUN -stop-> IDLE.
//   - RUN -limit reached-> DONE.
//   - DONE -start-> RUN.
//   - DONE -stop-> IDLE.
//   - RUN: start ignored.
//   - IDLE: stop ignored.
//   - start&stop together: in RUN, stop wins; in IDLE/DONE, start wins.
//  On start: match_count<=0, progress<=S0, timeout<=0; pattern/limit kept.
//  x_ready = (state==RUN) & ~stop (combinational); no symbol consumed in a stop cycle.
//  Progress FSM (advances only on accepted symbol s):
//   - S0: s==p0 -> S1, else S0.
//   - S1: s==p1 -> S2; elif s==p0 -> S1; else S0.
//   - S2: s==p2 -> S3; elif s==p0 -> S1; else S0.
//   - S3: s==p0 -> S1, else S0.
//  Fallback is fixed to "s==p0 ? S1 : S0" (no general overlap search), including repeated-symbol patterns.
//  Match: on the edge entering S3:
//   - z=1 in the next cycle only; match_count+1, wrapping at 2^CNT_W.
//   - S3 held without new symbols -> z stays 0 after the first cycle.
//  Limit: if limit!=0 and the incremented count == limit, state->DONE on the same edge as the z pulse.
//  Limit=0: never DONE by count; RUN until stop.
//  Stop mid-sequence: progress<=S0 at the stop edge; count, pattern and limit hold.
//  Leaving RUN: IDLE/DONE keep match_count stable for readout.
//  cfg_we: in RUN ignored entirely; in IDLE/DONE loads both fields on the edge.
//  cfg_we & start same cycle in IDLE/DONE: new config applies to the run being started.
//  Latency: symbol accepted at edge k -> z visible after edge k.
//  Reset mid-RUN: all state returns to reset values at the next edge.
// CONFIGURATION
//  SEQ_CTRL_TIMEOUT_EN defined:
//   - idle counter clears on each accepted symbol and on entering RUN.
//   - Reaching TIMEOUT_CYC consecutive RUN cycles without one -> DONE, timeout=1 (sticky until start/reset).
//  Undefined: no timer logic; timeout tied to 0; RUN waits indefinitely.
// TESTING
//  1 reset, start, x=11,01,10 -> one z pulse 1 cycle after the third symbol; match_count=1; busy=1.
//  2 stream 11,11,01,10,01,10 -> exactly one match; stream 11,01,11,01,10 -> exactly one match.
//  3 cfg_limit=2, start, 11,01,10,11,01,10 -> DONE with z on the 2nd match; x_ready=0; count=2.
//  4 start, 11,01, then stop, then start, 10 -> no z; count=0.
//  5 cfg_we pattern {00,10,01} during RUN -> ignored, 11,01,10 still matches; after stop the load takes effect.
//  6 with SEQ_CTRL_TIMEOUT_EN, TIMEOUT_CYC=16: start, no x_valid for 16 cycles -> done=1, timeout=1; start clears timeout.

Source files
------------

// File: rtl/seq_recognizer_ctrl.sv
// seq_recognizer_ctrl: run controller for a 3-symbol sequence recognizer.
// Holds a programmable pattern {p0,p1,p2}, consumes a valid/ready symbol
// stream while running, pulses o_z one cycle after each completed pattern,
// counts matches and stops on its own after a programmed match limit.
// Optional feature macro: SEQ_CTRL_TIMEOUT_EN (idle-cycle watchdog in RUN).
module seq_recognizer_ctrl #(
  parameter int SYM_W       = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cfg_we,
  input  logic [3*SYM_W-1:0] i_cfg_pattern,
  input  logic [CNT_W-1:0]   i_cfg_limit,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_x_valid,
  input  logic [SYM_W-1:0]   i_x,
  output logic               o_x_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_z,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {P_S0, P_S1, P_S2, P_S3} prog_t;

  // Power-on pattern 11,01,10 with p0 in the MSBs.
  localparam logic [3*SYM_W-1:0] DEF_PAT = {SYM_W'(3), SYM_W'(1), SYM_W'(2)};

  state_t               r_state, w_state_nxt;
  prog_t                r_prog,  w_prog_nxt;
  logic [3*SYM_W-1:0]   r_pattern;
  logic [CNT_W-1:0]     r_limit;
  logic [CNT_W-1:0]     r_count, w_count_nxt, w_count_inc;
  logic                 r_z;
  logic                 w_acc, w_match, w_arm, w_tmo_hit;
  logic [SYM_W-1:0]     w_p0, w_p1, w_p2;
  prog_t                w_fallback;

  assign w_p0 = r_pattern[3*SYM_W-1 -: SYM_W];
  assign w_p1 = r_pattern[2*SYM_W-1 -: SYM_W];
  assign w_p2 = r_pattern[SYM_W-1:0];

  // A stop cycle never consumes a symbol, so ready drops with stop.
  assign o_x_ready = (r_state == ST_RUN) & ~i_stop;
  assign o_busy    = (r_state == ST_RUN);
  assign o_done    = (r_state == ST_DONE);
  assign o_z       = r_z;
  assign o_match_count = r_count;

  assign w_acc       = i_x_valid & o_x_ready;
  assign w_count_inc = r_count + CNT_W'(1);
  // Restart rule deliberately ignores partial overlaps: only p0 re-arms S1.
  assign w_fallback  = (i_x == w_p0) ? P_S1 : P_S0;

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_inc;
  logic          r_timeout;

  assign w_idle_inc = r_idle + IW'(1);
  assign w_tmo_hit  = (r_state == ST_RUN) & ~i_stop & ~w_acc &
                      (w_idle_inc == IW'(TIMEOUT_CYC));
  assign o_timeout  = r_timeout;

  // Idle-cycle counter: restarts on every accepted symbol and on arming.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_arm || w_acc || r_state != ST_RUN) r_idle <= '0;
    else                                                r_idle <= w_idle_inc;
  end

  // Sticky timeout flag, cleared only by start or reset.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_arm) r_timeout <= 1'b0;
    else if (w_tmo_hit)   r_timeout <= 1'b1;
  end
`else
  assign w_tmo_hit = 1'b0;
  // No watchdog in this build; the parameter has no effect here.
  assign o_timeout = (TIMEOUT_CYC < 0);
`endif

  // State, progress and counter registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_prog  <= P_S0;
      r_count <= '0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prog  <= w_prog_nxt;
      r_count <= w_count_nxt;
      r_z     <= w_match;
    end
  end

  // Configuration loads only outside RUN; a same-cycle start sees the new values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pattern <= DEF_PAT;
      r_limit   <= '0;
    end else if (i_cfg_we && r_state != ST_RUN) begin
      r_pattern <= i_cfg_pattern;
      r_limit   <= i_cfg_limit;
    end
  end

  // Next-state, progress step, match detection and limit check.
  always_comb begin
    w_state_nxt = r_state;
    w_prog_nxt  = r_prog;
    w_count_nxt = r_count;
    w_match     = 1'b0;
    w_arm       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_arm       = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
          w_prog_nxt  = P_S0;
        end else begin
          if (w_acc) begin
            case (r_prog)
              P_S0:    w_prog_nxt = (i_x == w_p0) ? P_S1 : P_S0;
              P_S1:    w_prog_nxt = (i_x == w_p1) ? P_S2 : w_fallback;
              P_S2:    w_prog_nxt = (i_x == w_p2) ? P_S3 : w_fallback;
              default: w_prog_nxt = w_fallback;
            endcase
            w_match = (r_prog == P_S2) && (i_x == w_p2);
          end
          if (w_match) begin
            w_count_nxt = w_count_inc;
            if (r_limit != '0 && w_count_inc == r_limit) w_state_nxt = ST_DONE;
          end
          if (w_tmo_hit) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_arm       = 1'b1;
        end else if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_arm) begin
      w_count_nxt = '0;
      w_prog_nxt  = P_S0;
    end
  end

endmodule

// File: tb/tb_seq_recognizer_ctrl.sv
// Scoreboard bench for seq_recognizer_ctrl: each accepted symbol pushes the
// expected o_z for the cycle after it; a monitor pops and compares.
module tb_seq_recognizer_ctrl;
  localparam int SYM_W = 2;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst, cfg_we, start, stop, x_valid;
  logic [3*SYM_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_limit;
  logic [SYM_W-1:0] x;
  logic             x_ready, busy, done, z, timeout;
  logic [CNT_W-1:0] match_count;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];

  seq_recognizer_ctrl #(.SYM_W(SYM_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .i_clock(clk), .i_reset(rst), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
    .i_cfg_limit(cfg_limit), .i_start(start), .i_stop(stop), .i_x_valid(x_valid),
    .i_x(x), .o_x_ready(x_ready), .o_busy(busy), .o_done(done), .o_z(z),
    .o_match_count(match_count), .o_timeout(timeout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: after each edge, z must equal the scoreboard head if a symbol was taken, else 0.
  bit mon_acc;
  always @(posedge clk) begin
    mon_acc = x_valid & x_ready;
    #1;
    if (mon_acc) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else                   chk("z", z, exp_q.pop_front());
    end else begin
      chk("z_idle", z, 0);
    end
  end

  task automatic send(input logic [SYM_W-1:0] s, input bit e);
    @(negedge clk);
    x_valid = 1'b1;
    x = s;
    exp_q.push_back(e);
    @(posedge clk);
    #2 x_valid = 1'b0;
  endtask

  task automatic ctl(input logic st, input logic sp, input logic we,
                     input logic [3*SYM_W-1:0] pat, input logic [CNT_W-1:0] lim);
    @(negedge clk);
    start = st; stop = sp; cfg_we = we; cfg_pattern = pat; cfg_limit = lim;
    @(posedge clk);
    #2 begin start = 0; stop = 0; cfg_we = 0; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; cfg_we = 0; start = 0; stop = 0; x_valid = 0; x = '0;
    cfg_pattern = '0; cfg_limit = '0;
    idle(2);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", x_ready, 0);
    chk("rst_z", z, 0);
    chk("rst_count", match_count, 0);
    chk("rst_timeout", timeout, 0);

    // Basic match with the default pattern.
    ctl(1, 0, 0, '0, '0);
    send(2'b11, 0); send(2'b01, 0); send(2'b10, 1);
    chk("t1_count", match_count, 1);
    chk("t1_busy", busy, 1);
    idle(2);
    chk("t1_z_hold", z, 0);

    // Start in RUN is ignored.
    ctl(1, 0, 0, '0, '0);
    chk("start_in_run_count", match_count, 1);

    // Overlapping streams.
    send(2'b11, 0); send(2'b11, 0); send(2'b01, 0); send(2'b10, 1); send(2'b01, 0); send(2'b10, 0);
    chk("t2a_count", match_count, 2);
    send(2'b11, 0); send(2'b01, 0); send(2'b11, 0); send(2'b01, 0); send(2'b10, 1);
    chk("t2b_count", match_count, 3);

    // start & stop together in RUN: stop wins, count held.
    ctl(1, 1, 0, '0, '0);
    chk("stopwin_busy", busy, 0);
    chk("stop_count_hold", match_count, 3);

    // Limit 2 loaded together with start.
    ctl(1, 0, 1, 6'b110110, 8'd2);
    chk("t3_count_clr", match_count, 0);
    send(2'b11, 0); send(2'b01, 0); send(2'b10, 1);
    chk("t3_busy_mid", busy, 1);
    send(2'b11, 0); send(2'b01, 0); send(2'b10, 1);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ready", x_ready, 0);
    chk("t3_count", match_count, 2);
    @(negedge clk); x_valid = 1; x = 2'b11;
    @(posedge clk); #2 x_valid = 0;
    chk("done_no_accept", match_count, 2);
    ctl(0, 1, 0, '0, '0);
    chk("done_stop_done", done, 0);
    chk("done_stop_busy", busy, 0);

    // Stop mid-sequence clears progress.
    ctl(0, 0, 1, 6'b110110, 8'd0);
    ctl(1, 1, 0, '0, '0);
    chk("startwin_idle", busy, 1);
    send(2'b11, 0); send(2'b01, 0);
    ctl(0, 1, 0, '0, '0);
    ctl(1, 0, 0, '0, '0);
    send(2'b10, 0);
    chk("t4_count", match_count, 0);

    // Config writes during RUN are ignored.
    ctl(0, 0, 1, 6'b001001, 8'd1);
    send(2'b11, 0); send(2'b01, 0); send(2'b10, 1);
    chk("t5_count", match_count, 1);
    chk("t5_busy", busy, 1);
    ctl(0, 1, 0, '0, '0);
    ctl(0, 0, 1, 6'b001001, 8'd0);
    ctl(1, 0, 0, '0, '0);
    send(2'b00, 0); send(2'b10, 0); send(2'b01, 1);
    send(2'b11, 0); send(2'b01, 0); send(2'b10, 0);
    chk("t5_new_count", match_count, 1);

    // Repeated-symbol pattern uses the fixed p0 fallback only.
    ctl(1, 1, 0, '0, '0);
    ctl(1, 0, 1, 6'b010110, 8'd0);
    send(2'b01, 0); send(2'b01, 0); send(2'b01, 0); send(2'b10, 0);
    chk("rep_count", match_count, 0);

    // Reset mid-RUN restores defaults.
    send(2'b01, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #2 rst = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", x_ready, 0);
    ctl(1, 0, 0, '0, '0);
    send(2'b11, 0); send(2'b01, 0); send(2'b10, 1);
    chk("mrst_count", match_count, 1);

    // Idle behaviour in RUN.
    ctl(1, 0, 0, '0, '0);
    idle(TMO - 1);
    chk("tmo_early_done", done, 0);
    idle(1);
`ifdef SEQ_CTRL_TIMEOUT_EN
    chk("tmo_done", done, 1);
    chk("tmo_flag", timeout, 1);
    ctl(1, 0, 0, '0, '0);
    chk("tmo_clr", timeout, 0);
    chk("tmo_rearm", busy, 1);
`else
    chk("notmo_busy", busy, 1);
    chk("notmo_flag", timeout, 0);
`endif

    idle(2);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
